control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning program counter address width (max 12).
REQ-002 SHALL have port i_clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, meaning a synchronous, active-high reset.
REQ-004 SHALL have port i_instruction, input, 16, meaning the instruction word from the program counter stage.
REQ-005 SHALL have port i_zero, input, 1, meaning the ALU accumulator-is-zero flag.
REQ-006 SHALL have port i_mem_ready, input, 1, meaning the data memory has completed the current request.
REQ-007 SHALL have port o_pc_inc, output, 1, meaning advance PC by one.
REQ-008 SHALL have port o_pc_load, output, 1, meaning load PC from o_pc_addr.
REQ-009 SHALL have port o_pc_addr, output, ADDR_WIDTH, meaning the jump target.
REQ-010 SHALL have port o_alu_op, output, 4, meaning the ALU operation select.
REQ-011 SHALL have port o_reg_we, output, 1, meaning the register write enable.
REQ-012 SHALL have port o_imm, output, 8, meaning the immediate/address field.
REQ-013 SHALL have port o_mem_req, output, 1, meaning a data memory request.
REQ-014 SHALL have port o_mem_we, output, 1, meaning the request is a write.
REQ-015 SHALL have port o_halted, output, 1, meaning the sequencer is in HALT.

Function
REQ-016 SHALL decode opcode = i_instruction[15:12]: 0x0 NOP, 0x1 ALU, 0x2 LOADI, 0x3 LOAD, 0x4 STORE, 0x5 JMP, 0x6 JZ, 0xE HALT, others NOP.
REQ-017 SHALL implement states BUBBLE, EXEC, MEM_WAIT, HALT, encoded as a registered state.
REQ-018 SHALL ignore i_instruction in BUBBLE, drive o_pc_inc=1, and go to EXEC; this covers the PC stage's one-cycle stale output after load or reset.
REQ-019 SHALL, in EXEC for NOP/ALU/LOADI, assert o_pc_inc=1 for one cycle and stay in EXEC.
REQ-020 SHALL, for ALU, assert o_reg_we=1 and o_alu_op=i_instruction[11:8] in that cycle.
REQ-021 SHALL, for LOADI, assert o_reg_we=1 with o_imm=i_instruction[7:0].
REQ-022 SHALL, in EXEC for LOAD/STORE, assert o_mem_req=1 (o_mem_we=1 for STORE) with o_imm=i_instruction[7:0], hold o_pc_inc=0, and go to MEM_WAIT.
REQ-023 SHALL, in MEM_WAIT, hold o_mem_req, o_mem_we and o_imm stable from the latched instruction.
REQ-024 SHALL, in MEM_WAIT while i_mem_ready=1, assert o_pc_inc=1 and return to EXEC; for LOAD it SHALL also assert o_reg_we=1 in that cycle.
REQ-025 SHALL remain in MEM_WAIT indefinitely while i_mem_ready=0, with no timeout.
REQ-026 SHALL ignore i_mem_ready outside MEM_WAIT.
REQ-027 SHALL, for JMP, assert o_pc_load=1 with o_pc_addr=i_instruction[ADDR_WIDTH-1:0] and go to BUBBLE.
REQ-028 SHALL, for JZ with i_zero=1, behave as JMP.
REQ-029 SHALL, for JZ with i_zero=0, behave as NOP.
REQ-030 SHALL sample i_zero in the EXEC cycle of the JZ.
REQ-031 SHALL never assert o_pc_inc and o_pc_load in the same cycle; load wins by construction.
REQ-032 SHALL, for HALT, deassert all strobes, go to HALT, and assert o_halted=1 from the next cycle.
REQ-033 SHALL leave HALT only via i_reset.
REQ-034 SHALL let PC wrap-around be the PC stage's concern; the sequencer adds no wrap check.
REQ-035 SHALL drive all outputs combinationally from state plus the latched or current instruction, glitch-free relative to i_clk.

Reset
REQ-036 SHALL, with i_reset=1 at a rising edge, enter BUBBLE, clear the latched instruction to 0x0000, and deassert o_halted.
REQ-037 SHALL, during and immediately after reset, hold o_pc_load, o_reg_we, o_mem_req and o_mem_we at 0.
REQ-038 SHALL let reset mid MEM_WAIT abandon the request, dropping o_mem_req the cycle after the reset edge.
REQ-039 SHALL give i_reset priority over every transition, including HALT.

Verification
REQ-040 SHALL verify reset then stream 0x0000, 0x1300: cycle 0 BUBBLE with inc=1, then NOP with inc=1, then ALU with reg_we=1, alu_op=3, inc=1.
REQ-041 SHALL verify JMP 0x5042 (ADDR_WIDTH=8): pc_load=1, pc_addr=0x42, inc=0; next cycle BUBBLE ignores i_instruction=0xFFFF, inc=1.
REQ-042 SHALL verify LOAD 0x3010 with i_mem_ready low 3 cycles: mem_req=1, imm=0x10, inc=0 for 4 cycles; on ready, reg_we=1 and inc=1, then EXEC.
REQ-043 SHALL verify JZ 0x6020: with i_zero=0, inc=1 and no load; with i_zero=1, pc_load=1 and pc_addr=0x20.
REQ-044 SHALL verify HALT 0xE000 followed by arbitrary instructions: o_halted=1 and no strobes until i_reset; after reset, BUBBLE.
REQ-045 SHALL verify STORE 0x4005 with i_reset asserted in MEM_WAIT: mem_we=1 until reset, then all strobes 0 and state BUBBLE.

Source files
------------

// File: rtl/control_sequencer.sv
// Instruction sequencer: decodes one 16-bit instruction per EXEC cycle and drives
// the PC, ALU, register-file and data-memory strobes through a four-state FSM.
module control_sequencer #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [15:0]           i_instruction,
    input  logic                  i_zero,
    input  logic                  i_mem_ready,
    output logic                  o_pc_inc,
    output logic                  o_pc_load,
    output logic [ADDR_WIDTH-1:0] o_pc_addr,
    output logic [3:0]            o_alu_op,
    output logic                  o_reg_we,
    output logic [7:0]            o_imm,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic                  o_halted,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        ST_BUBBLE   = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU   = 4'h1;
    localparam logic [3:0] OP_LOADI = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_JZ    = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hE;

    state_t     state_q, state_d;
    logic       mem_store_q, mem_store_d;
    logic [7:0] mem_imm_q, mem_imm_d;
    logic [3:0] opcode;

    // Raw strobes before the reset override.
    logic pc_load_raw, reg_we_raw, mem_req_raw, mem_we_raw;

    assign opcode = i_instruction[15:12];

    // Only the parts of a LOAD/STORE needed while waiting on memory are latched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_BUBBLE;
            mem_store_q <= 1'b0;
            mem_imm_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            mem_store_q <= mem_store_d;
            mem_imm_q   <= mem_imm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_store_d = mem_store_q;
        mem_imm_d   = mem_imm_q;
        case (state_q)
            ST_BUBBLE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        state_d     = ST_MEM_WAIT;
                        mem_store_d = (opcode == OP_STORE);
                        mem_imm_d   = i_instruction[7:0];
                    end
                    OP_JMP:  state_d = ST_BUBBLE;
                    OP_JZ:   state_d = i_zero ? ST_BUBBLE : ST_EXEC;
                    OP_HALT: state_d = ST_HALT;
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_MEM_WAIT: state_d = i_mem_ready ? ST_EXEC : ST_MEM_WAIT;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_BUBBLE;
        endcase
    end

    // Data fields idle at zero whenever the strobe that qualifies them is inactive.
    always_comb begin
        o_pc_inc    = 1'b0;
        pc_load_raw = 1'b0;
        o_pc_addr   = '0;
        o_alu_op    = 4'h0;
        reg_we_raw  = 1'b0;
        o_imm       = 8'h00;
        mem_req_raw = 1'b0;
        mem_we_raw  = 1'b0;
        case (state_q)
            ST_BUBBLE: o_pc_inc = 1'b1;
            ST_EXEC: begin
                case (opcode)
                    OP_NOP: o_pc_inc = 1'b1;
                    OP_ALU: begin
                        o_pc_inc   = 1'b1;
                        reg_we_raw = 1'b1;
                        o_alu_op   = i_instruction[11:8];
                    end
                    OP_LOADI: begin
                        o_pc_inc   = 1'b1;
                        reg_we_raw = 1'b1;
                        o_imm      = i_instruction[7:0];
                    end
                    OP_LOAD, OP_STORE: begin
                        mem_req_raw = 1'b1;
                        mem_we_raw  = (opcode == OP_STORE);
                        o_imm       = i_instruction[7:0];
                    end
                    OP_JMP: begin
                        pc_load_raw = 1'b1;
                        o_pc_addr   = i_instruction[ADDR_WIDTH-1:0];
                    end
                    OP_JZ: begin
                        if (i_zero) begin
                            pc_load_raw = 1'b1;
                            o_pc_addr   = i_instruction[ADDR_WIDTH-1:0];
                        end else begin
                            o_pc_inc = 1'b1;
                        end
                    end
                    OP_HALT: o_pc_inc = 1'b0;
                    default: o_pc_inc = 1'b1;
                endcase
            end
            ST_MEM_WAIT: begin
                mem_req_raw = 1'b1;
                mem_we_raw  = mem_store_q;
                o_imm       = mem_imm_q;
                if (i_mem_ready) begin
                    o_pc_inc   = 1'b1;
                    reg_we_raw = ~mem_store_q;
                end
            end
            default: o_pc_inc = 1'b0;
        endcase
    end

    // Side-effecting strobes are suppressed for the whole reset cycle.
    assign o_pc_load = pc_load_raw & ~i_reset;
    assign o_reg_we  = reg_we_raw  & ~i_reset;
    assign o_mem_req = mem_req_raw & ~i_reset;
    assign o_mem_we  = mem_we_raw  & ~i_reset;
    assign o_halted  = (state_q == ST_HALT);
    assign o_state   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a table of per-cycle vectors followed by
// hand-written multi-cycle sequences for memory wait, HALT and reset-in-MEM_WAIT.
module tb_control_sequencer;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   ins;
    logic          zero;
    logic          rdy;
    logic          pc_inc, pc_load, reg_we, mem_req, mem_we, halted;
    logic [AW-1:0] pc_addr;
    logic [3:0]    alu_op;
    logic [7:0]    imm;
    logic [1:0]    state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    control_sequencer #(.ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_reset(rst), .i_instruction(ins), .i_zero(zero),
        .i_mem_ready(rdy), .o_pc_inc(pc_inc), .o_pc_load(pc_load),
        .o_pc_addr(pc_addr), .o_alu_op(alu_op), .o_reg_we(reg_we), .o_imm(imm),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_halted(halted), .o_state(state)
    );

    typedef struct {
        logic        rst;
        logic [15:0] ins;
        logic        z;
        logic        rdy;
        logic        inc;
        logic        ld;
        logic [7:0]  addr;
        logic [3:0]  op;
        logic        we;
        logic [7:0]  imm;
        logic        mreq;
        logic        mwe;
        logic        hlt;
        logic [1:0]  st;
    } vec_t;

    localparam logic [1:0] S_BUB = 2'd0, S_EX = 2'd1, S_MW = 2'd2, S_HLT = 2'd3;

    function automatic vec_t mk(input logic r, input logic [15:0] i, input logic z,
                                input logic rd, input logic inc, input logic ld,
                                input logic [7:0] a, input logic [3:0] op,
                                input logic we, input logic [7:0] im, input logic mq,
                                input logic mw, input logic h, input logic [1:0] s);
        vec_t v;
        v.rst = r; v.ins = i; v.z = z; v.rdy = rd; v.inc = inc; v.ld = ld;
        v.addr = a; v.op = op; v.we = we; v.imm = im; v.mreq = mq; v.mwe = mw;
        v.hlt = h; v.st = s;
        return v;
    endfunction

    // Inputs are driven 1ns after a rising edge and outputs sampled on the falling edge.
    task automatic apply(input string name, input vec_t v);
        logic [27:0] act, exp;
        rst = v.rst; ins = v.ins; zero = v.z; rdy = v.rdy;
        @(negedge clk);
        act = {pc_inc, pc_load, pc_addr, alu_op, reg_we, imm, mem_req, mem_we, halted, state};
        exp = {v.inc, v.ld, v.addr, v.op, v.we, v.imm, v.mreq, v.mwe, v.hlt, v.st};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got inc/ld/addr/op/we/imm/mreq/mwe/hlt/st=%07h expected %07h",
                     name, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[14];

    initial begin
        //               rst ins      z  rdy inc ld addr  op   we imm   mq mw h  st
        tbl[0]  = mk(1, 16'h1300, 0, 0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_BUB);
        tbl[1]  = mk(0, 16'hFFFF, 0, 0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_BUB);
        tbl[2]  = mk(0, 16'h0000, 0, 0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_EX);
        tbl[3]  = mk(0, 16'h1300, 0, 0, 1, 0, 8'h00, 4'h3, 1, 8'h00, 0, 0, 0, S_EX);
        tbl[4]  = mk(0, 16'h20A5, 0, 0, 1, 0, 8'h00, 4'h0, 1, 8'hA5, 0, 0, 0, S_EX);
        tbl[5]  = mk(0, 16'h5042, 0, 0, 0, 1, 8'h42, 4'h0, 0, 8'h00, 0, 0, 0, S_EX);
        tbl[6]  = mk(0, 16'hFFFF, 0, 0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_BUB);
        tbl[7]  = mk(0, 16'h6020, 0, 0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_EX);
        tbl[8]  = mk(0, 16'h6020, 1, 0, 0, 1, 8'h20, 4'h0, 0, 8'h00, 0, 0, 0, S_EX);
        tbl[9]  = mk(0, 16'h6020, 0, 0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_BUB);
        tbl[10] = mk(0, 16'h7123, 0, 0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_EX);
        tbl[11] = mk(0, 16'h1F00, 1, 1, 1, 0, 8'h00, 4'hF, 1, 8'h00, 0, 0, 0, S_EX);
        tbl[12] = mk(0, 16'h50FF, 0, 0, 0, 1, 8'hFF, 4'h0, 0, 8'h00, 0, 0, 0, S_EX);
        tbl[13] = mk(0, 16'h4005, 0, 1, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_BUB);

        rst = 1'b1; ins = 16'h0000; zero = 1'b0; rdy = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) apply($sformatf("tbl%0d", i), tbl[i]);

        // LOAD with memory not ready for three wait cycles; instruction bus changes meanwhile.
        apply("load_exec", mk(0, 16'h3010, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h10, 1, 0, 0, S_EX));
        for (int i = 0; i < 3; i++)
            apply($sformatf("load_wait%0d", i),
                  mk(0, 16'hFFFF, 1, 0, 0, 0, 8'h00, 4'h0, 0, 8'h10, 1, 0, 0, S_MW));
        apply("load_ready", mk(0, 16'hFFFF, 0, 1, 1, 0, 8'h00, 4'h0, 1, 8'h10, 1, 0, 0, S_MW));
        apply("load_back", mk(0, 16'h0000, 0, 1, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_EX));

        // HALT absorbs every later instruction until reset.
        apply("halt_exec", mk(0, 16'hE000, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_EX));
        apply("halt_jmp",  mk(0, 16'h5042, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 1, S_HLT));
        apply("halt_load", mk(0, 16'h3010, 0, 1, 0, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 1, S_HLT));
        apply("halt_alu",  mk(0, 16'h1300, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 1, S_HLT));
        apply("halt_jz",   mk(0, 16'h6020, 1, 0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 1, S_HLT));
        apply("halt_rst",  mk(1, 16'h2011, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 1, S_HLT));
        apply("halt_bub",  mk(0, 16'h1300, 0, 0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_BUB));
        apply("halt_run",  mk(0, 16'h0000, 0, 0, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_EX));

        // STORE abandoned by reset while waiting on memory.
        apply("st_exec",  mk(0, 16'h4005, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h05, 1, 1, 0, S_EX));
        apply("st_wait0", mk(0, 16'h0000, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h05, 1, 1, 0, S_MW));
        apply("st_wait1", mk(0, 16'h1300, 1, 0, 0, 0, 8'h00, 4'h0, 0, 8'h05, 1, 1, 0, S_MW));
        apply("st_rst",   mk(1, 16'h1300, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h05, 0, 0, 0, S_MW));
        apply("st_bub",   mk(0, 16'h1300, 0, 1, 1, 0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 0, S_BUB));
        apply("st_after", mk(0, 16'h1300, 0, 1, 1, 0, 8'h00, 4'h3, 1, 8'h00, 0, 0, 0, S_EX));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
